traffic_sensor_conditioner: RTL and testbench

Upstream conditioning stage for the traffic-light controller. It takes the raw, asynchronous car-presence sensor lines for streets A and B and produces the clean, synchronized `sA`/`sB` levels the light FSM samples. It also produces the one-cycle `tick` that the top level routes to the light FSM's state-register enable, so lights advance at human timescales while everything runs on `clk`. Three things happen here: metastability protection, debounce, and tick generation.

---
 rtl/traffic_pkg.sv | 19 +
 rtl/traffic_sensor_conditioner_if.sv | 11 +
 rtl/sensor_debounce.sv | 73 +++++++
 rtl/traffic_sensor_conditioner.sv | 58 +++++
 tb/tb_traffic_sensor_conditioner.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared constants and light-controller encodings for the traffic-light slice.
package traffic_pkg;
  localparam int DEB_CYCLES_DEF = 4;
  localparam int TICK_DIV_DEF   = 50_000_000;
  localparam int HOLD_TICKS_DEF = 2;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } light_t;

  typedef enum logic [1:0] {
    ST_A_GREEN  = 2'd0,
    ST_A_YELLOW = 2'd1,
    ST_B_GREEN  = 2'd2,
    ST_B_YELLOW = 2'd3
  } light_state_t;
endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// Sensor-in / conditioned-out bundle between the raw sensors and the light FSM.
interface traffic_sensor_conditioner_if;
  logic rawA;
  logic rawB;
  logic sA;
  logic sB;
  logic tick;

  modport master (output rawA, rawB, input sA, sB, tick);
  modport slave  (input rawA, rawB, output sA, sB, tick);
endinterface

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchronizer, run-length debouncer and, with
// SENSOR_STRETCH_EN defined, a tick-counted hold stretcher on rising edges.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
`ifdef SENSOR_STRETCH_EN
  , parameter int HOLD_TICKS = HOLD_TICKS_DEF
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_s
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_deb;
  logic [CW-1:0] r_cnt;
  logic          w_q2;
  logic          w_accept;
  logic          w_deb_nxt;

  assign w_q2      = r_sync[1];
  assign w_accept  = (w_q2 != r_deb) && (r_cnt == CMAX);
  assign w_deb_nxt = w_accept ? w_q2 : r_deb;

  // Any sample matching the accepted level restarts the run count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_deb  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_deb  <= w_deb_nxt;
      if ((w_q2 == r_deb) || w_accept) r_cnt <= '0;
      else                             r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef SENSOR_STRETCH_EN
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  logic [HW-1:0] r_hcnt;
  logic [HW-1:0] w_hcnt_nxt;
  logic          r_s;

  // A fresh rise reloads the hold even if a tick lands in the same cycle.
  always_comb begin
    w_hcnt_nxt = r_hcnt;
    if (w_accept && w_q2)              w_hcnt_nxt = HW'(HOLD_TICKS);
    else if (i_tick && (r_hcnt != '0)) w_hcnt_nxt = r_hcnt - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcnt <= '0;
      r_s    <= 1'b0;
    end else begin
      r_hcnt <= w_hcnt_nxt;
      r_s    <= w_deb_nxt | (w_hcnt_nxt != '0);
    end
  end

  assign o_s = r_s;
`else
  assign o_s = r_deb;
`endif
endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the A/B car sensors and generates the light-advance tick.
// Optional hold stretch on each channel is enabled by SENSOR_STRETCH_EN.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  traffic_sensor_conditioner_if.slave  sif
);
  localparam int NUM_LANES = 2;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);

  if (DEB_CYCLES < 1 || TICK_DIV < 2 || HOLD_TICKS < 0) begin : g_cfg_chk
    $error("traffic_sensor_conditioner: illegal parameter set");
  end

  logic [TW-1:0]        r_tcnt;
  logic                 r_tick;
  logic [NUM_LANES-1:0] w_raw;
  logic [NUM_LANES-1:0] w_s;

  // Free-running divider; the pulse is registered so it lands the cycle after wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_tcnt == TMAX);
      r_tcnt <= (r_tcnt == TMAX) ? '0 : r_tcnt + 1'b1;
    end
  end

  assign w_raw = {sif.rawB, sif.rawA};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    sensor_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
`ifdef SENSOR_STRETCH_EN
      , .HOLD_TICKS(HOLD_TICKS)
`endif
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .i_raw  (w_raw[l]),
      .i_tick (r_tick),
      .o_s    (w_s[l])
    );
  end

  assign sif.sA   = w_s[0];
  assign sif.sB   = w_s[1];
  assign sif.tick = r_tick;
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: randomized and directed sensor traffic
// against a run-length / edge-count reference model.
module tb_traffic_sensor_conditioner;
  import traffic_pkg::*;

  localparam int DEB  = 4;
  localparam int TD   = 8;
  localparam int HOLD = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  traffic_sensor_conditioner_if sif();

  traffic_sensor_conditioner #(
    .DEB_CYCLES(DEB), .TICK_DIV(TD), .HOLD_TICKS(HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the sensor is seen two captures late, a level is accepted
  // once it has been seen DEB times in a row, ticks fall on multiples of TD.
  bit dly   [2][2];
  bit run_v [2];
  int run_n [2];
  bit m_deb [2];
  int m_hold[2];
  bit m_s   [2];
  bit m_tick;
  int m_edges;

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      dly[c][0] = 1'b0; dly[c][1] = 1'b0;
      run_v[c] = 1'b0; run_n[c] = 0;
      m_deb[c] = 1'b0; m_hold[c] = 0; m_s[c] = 1'b0;
    end
    m_tick  = 1'b0;
    m_edges = 0;
  endtask

  task automatic model_step();
    bit t_in;
    bit v;
    bit prev;
    bit raw_now[2];
    raw_now[0] = sif.rawA;
    raw_now[1] = sif.rawB;
    t_in = m_tick;
    m_edges++;
    m_tick = ((m_edges % TD) == 0);
    for (int c = 0; c < 2; c++) begin
      v = dly[c][1];
      dly[c][1] = dly[c][0];
      dly[c][0] = raw_now[c];
      if (v == run_v[c]) run_n[c]++;
      else begin run_v[c] = v; run_n[c] = 1; end
      prev = m_deb[c];
      if (run_v[c] != m_deb[c] && run_n[c] >= DEB) m_deb[c] = run_v[c];
`ifdef SENSOR_STRETCH_EN
      if (!prev && m_deb[c])          m_hold[c] = HOLD;
      else if (t_in && m_hold[c] > 0) m_hold[c]--;
      m_s[c] = m_deb[c] || (m_hold[c] > 0);
`else
      m_s[c] = m_deb[c];
`endif
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    sif.rawA = 1'b0; sif.rawB = 1'b0;
    reset = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    checks++;
    if ({sif.sA, sif.sB, sif.tick} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs got sA/sB/tick=%b%b%b want 000", sif.sA, sif.sB, sif.tick);
    end
    reset = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      checks++;
      if (sif.tick !== (n == TD)) begin
        failures++;
        $display("FAIL reset_first_tick cyc=%0d got tick=%b want %b", n, sif.tick, (n == TD));
      end
    end
  endtask

  task automatic test_latency();
    int e;
    sif.rawA = 1'b1;
    e = 0;
    do begin
      cyc(); e++;
      checks++;
      if ({sif.sA, sif.sB, sif.tick} !== {m_s[0], m_s[1], m_tick}) begin
        failures++;
        $display("FAIL latency_model e=%0d got %b%b%b want %b%b%b", e, sif.sA, sif.sB, sif.tick, m_s[0], m_s[1], m_tick);
      end
    end while (sif.sA !== 1'b1 && e < 30);
    checks++;
    if (e != DEB + 2) begin
      failures++;
      $display("FAIL latency_rise got edges=%0d want %0d", e, DEB + 2);
    end
    repeat (10) begin
      cyc();
      checks++;
      if (sif.sA !== 1'b1) begin
        failures++;
        $display("FAIL latency_hold got sA=%b want 1", sif.sA);
      end
    end
    sif.rawA = 1'b0;
    e = 0;
    do begin
      cyc(); e++;
      checks++;
      if ({sif.sA, sif.sB, sif.tick} !== {m_s[0], m_s[1], m_tick}) begin
        failures++;
        $display("FAIL latency_fall_model e=%0d got %b%b%b want %b%b%b", e, sif.sA, sif.sB, sif.tick, m_s[0], m_s[1], m_tick);
      end
    end while (sif.sA !== 1'b0 && e < 60);
`ifndef SENSOR_STRETCH_EN
    checks++;
    if (e != DEB + 2) begin
      failures++;
      $display("FAIL latency_fall got edges=%0d want %0d", e, DEB + 2);
    end
`endif
  endtask

  task automatic test_glitch();
    int hi;
    for (int w = DEB - 1; w <= DEB; w++) begin
      sif.rawB = 1'b1;
      repeat (w) cyc();
      sif.rawB = 1'b0;
      hi = 0;
      repeat (40) begin
        cyc();
        if (sif.sB === 1'b1) hi++;
        checks++;
        if ({sif.sA, sif.sB, sif.tick} !== {m_s[0], m_s[1], m_tick}) begin
          failures++;
          $display("FAIL glitch_model w=%0d got %b%b%b want %b%b%b", w, sif.sA, sif.sB, sif.tick, m_s[0], m_s[1], m_tick);
        end
      end
      checks++;
`ifndef SENSOR_STRETCH_EN
      if (hi != ((w < DEB) ? 0 : DEB)) begin
        failures++;
        $display("FAIL glitch_width w=%0d got high=%0d want %0d", w, hi, (w < DEB) ? 0 : DEB);
      end
`else
      if ((w < DEB) ? (hi != 0) : (hi < DEB)) begin
        failures++;
        $display("FAIL glitch_width w=%0d got high=%0d want %s", w, hi, (w < DEB) ? "0" : ">=4");
      end
`endif
    end
  endtask

  task automatic test_tick_cadence();
    int cnt;
    int last;
    bit prev_t;
    reset = 1'b1; model_clear();
    @(negedge clk);
    reset = 1'b0;
    cnt = 0; last = -1; prev_t = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      sif.rawA = 1'($urandom_range(0, 1));
      sif.rawB = 1'($urandom_range(0, 1));
      cyc();
      checks++;
      if ({sif.sA, sif.sB, sif.tick} !== {m_s[0], m_s[1], m_tick}) begin
        failures++;
        $display("FAIL cadence_model n=%0d got %b%b%b want %b%b%b", n, sif.sA, sif.sB, sif.tick, m_s[0], m_s[1], m_tick);
      end
      if (sif.tick === 1'b1) begin
        cnt++;
        checks++;
        if (prev_t || (last >= 0 && n - last != TD)) begin
          failures++;
          $display("FAIL cadence_spacing n=%0d got gap=%0d want %0d", n, n - last, TD);
        end
        last = n;
      end
      prev_t = (sif.tick === 1'b1);
    end
    checks++;
    if (cnt != 5) begin
      failures++;
      $display("FAIL cadence_count got ticks=%0d want 5", cnt);
    end
    sif.rawA = 1'b0; sif.rawB = 1'b0;
    repeat (40) cyc();
  endtask

  task automatic test_stretch();
    int hi;
    int thi;
    sif.rawA = 1'b1;
    repeat (DEB) cyc();
    sif.rawA = 1'b0;
    hi = 0; thi = 0;
    repeat (60) begin
      cyc();
      if (sif.sA === 1'b1) begin
        hi++;
        if (sif.tick === 1'b1) thi++;
      end
      checks++;
      if ({sif.sA, sif.sB, sif.tick} !== {m_s[0], m_s[1], m_tick}) begin
        failures++;
        $display("FAIL stretch_model got %b%b%b want %b%b%b", sif.sA, sif.sB, sif.tick, m_s[0], m_s[1], m_tick);
      end
    end
    checks++;
`ifdef SENSOR_STRETCH_EN
    if (thi != HOLD || hi < DEB) begin
      failures++;
      $display("FAIL stretch_hold got ticks_while_high=%0d high=%0d want ticks=%0d", thi, hi, HOLD);
    end
`else
    if (hi != DEB) begin
      failures++;
      $display("FAIL stretch_off got high=%0d want %0d", hi, DEB);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    sif.rawB = 1'b1;
    repeat (DEB + 4) cyc();
    sif.rawA = 1'b1;
    repeat (3) cyc();
    reset = 1'b1;
    model_clear();
    #1;
    checks++;
    if ({sif.sA, sif.sB, sif.tick} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid got sA/sB/tick=%b%b%b want 000", sif.sA, sif.sB, sif.tick);
    end
    @(negedge clk);
    reset = 1'b0;
    sif.rawA = 1'b0; sif.rawB = 1'b0;
    n = 0;
    do begin
      cyc(); n++;
    end while (sif.tick !== 1'b1 && n < 30);
    checks++;
    if (n != TD) begin
      failures++;
      $display("FAIL reset_mid_tick got cycles=%0d want %0d", n, TD);
    end
  endtask

  task automatic test_random();
    int rst_at;
    rst_at = $urandom_range(200, 500);
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) sif.rawA = ~sif.rawA;
      if ($urandom_range(0, 5) == 0) sif.rawB = ~sif.rawB;
      if (n % 97 < 12) begin sif.rawA = 1'b1; sif.rawB = (n % 2 == 0); end
      if (n == rst_at) begin reset = 1'b1; model_clear(); end
      if (n == rst_at + 2) reset = 1'b0;
      cyc();
      checks++;
      if ({sif.sA, sif.sB, sif.tick} !== {m_s[0], m_s[1], m_tick}) begin
        failures++;
        $display("FAIL random_model n=%0d got %b%b%b want %b%b%b", n, sif.sA, sif.sB, sif.tick, m_s[0], m_s[1], m_tick);
      end
    end
  endtask

  initial begin
    sif.rawA = 1'b0;
    sif.rawB = 1'b0;
    model_clear();
    test_reset();
    test_latency();
    test_glitch();
    test_tick_cadence();
    test_stretch();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
